// File: rtl/clkdiv_multi_if.sv
// Control/status bundle for clkdiv_multi: enables, divisor write port, divided outputs.
interface clkdiv_multi_if #(
  parameter int NCH   = 4,
  parameter int CH_W  = 2,
  parameter int DIV_W = 8
);
  logic [NCH-1:0]   en;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [DIV_W-1:0] wr_div;
  logic [NCH-1:0]   clkout;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pend;

  modport master (output en, wr_en, wr_ch, wr_div, input clkout, tick, pend);
  modport slave  (input en, wr_en, wr_ch, wr_div, output clkout, tick, pend);
endinterface

// File: rtl/clkdiv_multi.sv
// NCH-channel programmable clock divider with shadowed divisors reloaded at period boundaries.
// Optional macro CLKDIV_TICK_EN adds the per-channel tick strobe; otherwise tick is tied low.
module clkdiv_lane #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 16
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             clkout,
  output logic             tick,
  output logic             pend
);
  logic [DIV_W-1:0] cnt, act_div, shd_div, cnt_next, hi_len, wr_clamp;
  logic             wrap, reload;

  assign wrap     = (cnt == act_div - DIV_W'(1));
  assign cnt_next = wrap ? '0 : cnt + DIV_W'(1);
  assign hi_len   = (act_div >> 1) + {{(DIV_W-1){1'b0}}, act_div[0]};
  assign wr_clamp = (wr_div < DIV_W'(2)) ? DIV_W'(2) : wr_div;
  // A stopped channel has no period to finish, so a pending divisor lands immediately.
  assign reload   = pend && (!en || wrap);

  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt     <= '0;
      act_div <= DIV_W'(DEF_DIV);
      shd_div <= DIV_W'(DEF_DIV);
      pend    <= 1'b0;
      clkout  <= 1'b1;
    end else begin
      if (en) begin
        cnt    <= cnt_next;
        clkout <= (cnt_next < hi_len);
      end else begin
        cnt    <= '0;
        clkout <= 1'b1;
      end
      if (reload) act_div <= shd_div;
      // A write on the reload edge re-arms pend, deferring itself to the next boundary.
      if (wr) begin
        shd_div <= wr_clamp;
        pend    <= 1'b1;
      end else if (reload) begin
        pend    <= 1'b0;
      end
    end
  end

`ifdef CLKDIV_TICK_EN
  always_ff @(posedge clkin) begin
    if (reset) tick <= 1'b0;
    else       tick <= en && wrap;
  end
`else
  assign tick = 1'b0;
`endif
endmodule

module clkdiv_multi #(
  parameter int NCH     = 4,
  parameter int CH_W    = 2,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 16
) (
  input  logic          clkin,
  input  logic          reset,
  clkdiv_multi_if.slave bus
);
  logic [NCH-1:0] wr_hit;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    // Indices at or above NCH match no lane, so such writes vanish.
    assign wr_hit[g] = bus.wr_en && (bus.wr_ch == CH_W'(g));

    clkdiv_lane #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_lane (
      .clkin  (clkin),
      .reset  (reset),
      .en     (bus.en[g]),
      .wr     (wr_hit[g]),
      .wr_div (bus.wr_div),
      .clkout (bus.clkout[g]),
      .tick   (bus.tick[g]),
      .pend   (bus.pend[g])
    );
  end
endmodule
